sensor_frame_filter: RTL and testbench
======================================

Name: sensor_frame_filter

Overview:
- Receive-side consumer of the UART link: takes each byte from the serial receiver (data_rec / data_ready / data_error) and produces debounced obstacle flags for the drive logic.
- Adds a link watchdog. When the phone/sensor link goes silent, the outputs fall to a safe "obstacle everywhere" state so the car stops.
- Sits between the UART receiver and the motion/auto-drive controller.

Parameters:
- TIMEOUT_CYCLES, 10_000_000: clk cycles without a good frame before the link is declared down (100 ms at 100 MHz).
- STABLE_FRAMES, 3: consecutive good frames disagreeing with a filtered bit before that bit flips; legal range 1..15.
- BACK_EN, 0: 0 forces the back sensor bit to 0 everywhere; 1 makes it behave like the other bits.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: system clock, all logic on its rising edge.
- rst, input, 1: asynchronous active-high reset.
- data_rec, input, 8: received byte. Bit0 front, bit1 left, bit2 right, bit3 back (1 = obstacle). Bits 7:4 are ignored. Stable while data_ready is high.
- data_ready, input, 1: byte-ready level from the receiver. It comes from the divided 16x clock domain and is treated as asynchronous.
- data_error, input, 1: framing error for the current byte. Qualified together with data_ready.
- sensor, output, 4: filtered obstacle flags, same bit order as data_rec[3:0].
- link_up, output, 1: 1 while good frames keep arriving within TIMEOUT_CYCLES.
- new_frame, output, 1: one-cycle pulse per accepted good frame.
- err_cnt, output, ERR_W: count of rejected frames, saturating.

Behaviour:
- Reset (async, immediate) sets:
  - sync/edge flops and all filter counters: 0
  - watchdog counter: 0
  - link_up = 0, new_frame = 0, err_cnt = 0
  - sensor = SAFE, where SAFE = 4'b1111 with bit3 forced 0 if BACK_EN = 0 (i.e. 4'b0111 by default).
- Synchronizer and edge detect:
  - data_ready passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3.
  - frame_evt = s2 & ~s3.
  - data_rec[3:0] and data_error are sampled directly in the frame_evt cycle; the data is stable because data_ready is still high.
  - A held-high data_ready yields exactly one frame_evt.
- Frame classification in the frame_evt cycle:
  - Bad frame (data_error = 1): err_cnt increments, holding at all-ones. sensor, the filters and the watchdog are untouched, and new_frame stays 0.
  - Good frame (data_error = 0): new_frame = 1 on the next cycle, and the watchdog counter is cleared.
- Latency: a data_ready rising edge that setup-meets clk edge n gives new_frame high and the sensor update visible after clk edge n+3.
- Link FSM, two states:
  - DOWN:
    - A good frame loads sensor = raw directly, with the back bit masked and no filtering.
    - It clears the per-bit counters and moves to UP with link_up = 1.
  - UP:
    - Per bit i (bit3 skipped when BACK_EN = 0), on each good frame: if raw[i] == sensor[i], cnt[i] = 0.
    - Otherwise, if cnt[i] + 1 == STABLE_FRAMES, sensor[i] flips to raw[i] and cnt[i] = 0.
    - Otherwise cnt[i] increments.
    - cnt[i] is 4 bits wide.
- Watchdog (UP only):
  - The counter increments every cycle without a good frame.
  - When it reaches TIMEOUT_CYCLES − 1 it moves to DOWN. On the next cycle: link_up = 0, sensor = SAFE, cnt[] = 0, watchdog counter = 0.
  - The counter is idle and held at 0 in DOWN.
- Simultaneous events: a good frame in the same cycle the watchdog would expire wins. The counter clears and the FSM stays UP.
- STABLE_FRAMES = 1 means a single disagreeing good frame flips the bit.
- Reset asserted mid-frame aborts everything. A data_ready already high when reset releases produces no frame_evt if s1–s3 all capture 1. If s1–s3 capture a rising transition, that counts as a new edge.

Test Plan:
- Reset, then data_ready pulse with data_rec = 8'hF5, data_error = 0 ->
  - new_frame after 3 clk edges
  - link_up = 1
  - sensor = 4'b0101 (bit3 masked, BACK_EN = 0)
  - err_cnt = 0.
- UP with sensor = 4'b0101, STABLE_FRAMES = 3, three good frames with data_rec[3:0] = 4'b0100 ->
  - sensor[0] stays 1 after frames 1 and 2 and goes to 0 after frame 3.
  - Inserting a 4'b0101 frame between them restarts the count.
- Frames with data_error = 1 ->
  - err_cnt increments by 1 per frame; sensor and new_frame unchanged.
  - 300 error frames leave err_cnt = 255.
- UP, then no frames for TIMEOUT_CYCLES (use TIMEOUT_CYCLES = 50 in sim) ->
  - link_up falls at cycle 50 and sensor = 4'b0111.
  - The next good frame 4'b0000 gives sensor = 0000 immediately.
- Good frame edge arriving exactly at the expiry cycle -> link_up stays 1 and the watchdog restarts from 0.
- data_ready held high for 1000 cycles -> exactly one new_frame.
- Async rst pulse between clock edges mid-stream -> all outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/sensor_frame_filter_if.sv
// Receiver-to-filter link: UART byte handshake in, filtered obstacle flags out.
interface sensor_frame_filter_if #(
  parameter int ERR_W = 8
);
  logic [7:0]       data_rec;
  logic             data_ready;
  logic             data_error;
  logic [3:0]       sensor;
  logic             link_up;
  logic             new_frame;
  logic [ERR_W-1:0] err_cnt;

  // Receiver / test side: drives the byte handshake, observes the flags
  modport master (
    output data_rec, data_ready, data_error,
    input  sensor, link_up, new_frame, err_cnt
  );

  // Filter side: consumes the byte handshake, drives the flags
  modport slave (
    input  data_rec, data_ready, data_error,
    output sensor, link_up, new_frame, err_cnt
  );
endinterface

// File: rtl/sensor_frame_filter.sv
// Turns raw UART sensor bytes into debounced obstacle flags, with a link
// watchdog that falls back to "obstacle everywhere" when frames stop arriving.
module sensor_frame_filter #(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int STABLE_FRAMES  = 3,
  parameter bit BACK_EN        = 1'b0,
  parameter int ERR_W          = 8
) (
  input logic                  clk,
  input logic                  rst,
  sensor_frame_filter_if.slave bus
);

  localparam int         WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_FRAMES - 1);
  localparam logic [3:0] BIT_MASK  = BACK_EN ? 4'b1111 : 4'b0111;
  localparam logic [3:0] SAFE      = BIT_MASK;

  typedef enum logic {
    LINK_DOWN,
    LINK_UP
  } linkState_e;

  logic             s1_q, s2_q, s3_q;
  logic             frameEvt;
  logic             frameEvt_q;
  logic             frameErr_q;
  logic [3:0]       rawBits_q;
  logic             goodFrame;
  logic             badFrame;

  linkState_e       state_q, state_d;
  logic [3:0]       sensor_q, sensor_d;
  logic [3:0][3:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]  wdCnt_q, wdCnt_d;
  logic [ERR_W-1:0] errCnt_q;
  logic             newFrame_q;

  logic             unusedHighBits;

  assign unusedHighBits = ^bus.data_rec[7:4];

  assign frameEvt  = s2_q & ~s3_q;
  assign goodFrame = frameEvt_q & ~frameErr_q;
  assign badFrame  = frameEvt_q & frameErr_q;

  // Resynchronise data_ready, find its rising edge and capture the byte while
  // the receiver is still holding it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      frameEvt_q <= 1'b0;
      frameErr_q <= 1'b0;
      rawBits_q  <= 4'b0000;
    end else begin
      s1_q       <= bus.data_ready;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      frameEvt_q <= frameEvt;
      if (frameEvt) begin
        frameErr_q <= bus.data_error;
        rawBits_q  <= bus.data_rec[3:0];
      end
    end
  end

  // Count rejected frames (saturating) and pulse once per accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCnt_q   <= '0;
      newFrame_q <= 1'b0;
    end else begin
      newFrame_q <= goodFrame;
      if (badFrame && (errCnt_q != '1)) begin
        errCnt_q <= errCnt_q + ERR_W'(1);
      end
    end
  end

  // Link state, filtered flags, per-bit disagreement counters and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LINK_DOWN;
      sensor_q <= SAFE;
      cnt_q    <= '0;
      wdCnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      sensor_q <= sensor_d;
      cnt_q    <= cnt_d;
      wdCnt_q  <= wdCnt_d;
    end
  end

  // Next state: a good frame always beats a watchdog expiry in the same cycle;
  // while down the first good frame is trusted as-is so the car reacts at once.
  always_comb begin
    state_d  = state_q;
    sensor_d = sensor_q;
    cnt_d    = cnt_q;
    wdCnt_d  = wdCnt_q;
    case (state_q)
      LINK_DOWN: begin
        wdCnt_d = '0;
        if (goodFrame) begin
          sensor_d = rawBits_q & BIT_MASK;
          cnt_d    = '0;
          state_d  = LINK_UP;
        end
      end
      LINK_UP: begin
        if (goodFrame) begin
          wdCnt_d = '0;
          for (int i = 0; i < 4; i++) begin
            if (BIT_MASK[i]) begin
              if (rawBits_q[i] == sensor_q[i]) begin
                cnt_d[i] = 4'd0;
              end else if (cnt_q[i] == STABLE_M1) begin
                sensor_d[i] = rawBits_q[i];
                cnt_d[i]    = 4'd0;
              end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
              end
            end
          end
        end else if (wdCnt_q == WD_LAST) begin
          state_d  = LINK_DOWN;
          sensor_d = SAFE;
          cnt_d    = '0;
          wdCnt_d  = '0;
        end else begin
          wdCnt_d = wdCnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.sensor    = sensor_q;
  assign bus.link_up   = (state_q == LINK_UP);
  assign bus.new_frame = newFrame_q;
  assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_sensor_frame_filter.sv
// Directed bench for sensor_frame_filter with a short watchdog timeout.
module tb_sensor_frame_filter;

  localparam int TIMEOUT = 50;

  // Raw nibbles fed to the filter and the flags expected after each frame,
  // starting from sensor = 0101 with all counters clear.
  localparam logic [3:0] FILT_RAW [18] = '{
    4'b0100, 4'b0100, 4'b0100,
    4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0101, 4'b0101,
    4'b1101, 4'b1101, 4'b1101,
    4'b0011, 4'b0011, 4'b0011,
    4'b0101, 4'b0101, 4'b0101
  };
  localparam logic [3:0] FILT_EXP [18] = '{
    4'b0101, 4'b0101, 4'b0100,
    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0101,
    4'b0101, 4'b0101, 4'b0101,
    4'b0101, 4'b0101, 4'b0011,
    4'b0011, 4'b0011, 4'b0101
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checkCount = 0;
  int         errorCount = 0;
  logic       obsNf;
  logic [3:0] obsSensor;

  sensor_frame_filter_if #(.ERR_W(8)) bus ();

  sensor_frame_filter #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .STABLE_FRAMES (3),
    .BACK_EN       (1'b0),
    .ERR_W         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout got running want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // One full receiver byte: raise ready, sample flags when the frame lands,
  // then drop ready long enough for the synchroniser to see it low.
  task automatic applyStimulus(input logic [7:0] data, input logic err);
    @(negedge clk);
    bus.data_rec   = data;
    bus.data_error = err;
    bus.data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    obsNf     = bus.new_frame;
    obsSensor = bus.sensor;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    if (bus.sensor !== 4'b0111) begin errorCount++; $display("[TB] FAIL reset_sensor got %b want %b", bus.sensor, 4'b0111); end
    checkCount++;
    if (bus.link_up !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_link_up got %b want 0", bus.link_up); end
    checkCount++;
    if (bus.new_frame !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_new_frame got %b want 0", bus.new_frame); end
    checkCount++;
    if (bus.err_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
    checkCount++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_frame();
    @(negedge clk);
    bus.data_rec   = 8'hF5;
    bus.data_error = 1'b0;
    bus.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (bus.new_frame !== 1'b0) begin errorCount++; $display("[TB] FAIL first_early_pulse got %b want 0", bus.new_frame); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.new_frame !== 1'b1) begin errorCount++; $display("[TB] FAIL first_new_frame got %b want 1", bus.new_frame); end
    checkCount++;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL first_link_up got %b want 1", bus.link_up); end
    checkCount++;
    if (bus.sensor !== 4'b0101) begin errorCount++; $display("[TB] FAIL first_sensor got %b want %b", bus.sensor, 4'b0101); end
    checkCount++;
    if (bus.err_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL first_err_cnt got %0d want 0", bus.err_cnt); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.new_frame !== 1'b0) begin errorCount++; $display("[TB] FAIL first_pulse_width got %b want 0", bus.new_frame); end
    checkCount++;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_filter();
    for (int i = 0; i < 18; i++) begin
      applyStimulus({4'hA, FILT_RAW[i]}, 1'b0);
      if (obsSensor !== FILT_EXP[i]) begin
        errorCount++;
        $display("[TB] FAIL filter_step%0d got %b want %b", i, obsSensor, FILT_EXP[i]);
      end
      checkCount++;
      if (obsNf !== 1'b1) begin errorCount++; $display("[TB] FAIL filter_pulse%0d got %b want 1", i, obsNf); end
      checkCount++;
    end
  endtask

  task automatic test_errors();
    applyStimulus(8'h05, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(8'h00, 1'b1);
      if (obsNf !== 1'b0) begin errorCount++; $display("[TB] FAIL err_pulse%0d got %b want 0", k, obsNf); end
      checkCount++;
      if (obsSensor !== 4'b0101) begin errorCount++; $display("[TB] FAIL err_sensor%0d got %b want 0101", k, obsSensor); end
      checkCount++;
      if (bus.err_cnt !== 8'(k)) begin errorCount++; $display("[TB] FAIL err_count%0d got %0d want %0d", k, bus.err_cnt, k); end
      checkCount++;
      if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL err_link%0d got %b want 1", k, bus.link_up); end
      checkCount++;
    end
    for (int k = 4; k <= 300; k++) begin
      applyStimulus(8'h00, 1'b1);
    end
    if (bus.err_cnt !== 8'd255) begin errorCount++; $display("[TB] FAIL err_saturate got %0d want 255", bus.err_cnt); end
    checkCount++;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus.data_rec   = 8'h05;
    bus.data_error = 1'b0;
    bus.data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL wd_start_link got %b want 1", bus.link_up); end
    checkCount++;
    bus.data_ready = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL wd_before_expiry got %b want 1", bus.link_up); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.link_up !== 1'b0) begin errorCount++; $display("[TB] FAIL wd_expired_link got %b want 0", bus.link_up); end
    checkCount++;
    if (bus.sensor !== 4'b0111) begin errorCount++; $display("[TB] FAIL wd_safe_sensor got %b want 0111", bus.sensor); end
    checkCount++;
    repeat (3) @(negedge clk);
    applyStimulus(8'h00, 1'b0);
    if (obsSensor !== 4'b0000) begin errorCount++; $display("[TB] FAIL wd_recover_sensor got %b want 0000", obsSensor); end
    checkCount++;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL wd_recover_link got %b want 1", bus.link_up); end
    checkCount++;
  endtask

  task automatic test_expiry_race();
    @(negedge clk);
    bus.data_rec   = 8'h00;
    bus.data_error = 1'b0;
    bus.data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.data_ready = 1'b0;
    repeat (TIMEOUT - 4) @(posedge clk);
    @(negedge clk);
    bus.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL race_pre_link got %b want 1", bus.link_up); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL race_link got %b want 1", bus.link_up); end
    checkCount++;
    if (bus.new_frame !== 1'b1) begin errorCount++; $display("[TB] FAIL race_new_frame got %b want 1", bus.new_frame); end
    checkCount++;
    bus.data_ready = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    if (bus.link_up !== 1'b1) begin errorCount++; $display("[TB] FAIL race_restart_link got %b want 1", bus.link_up); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.link_up !== 1'b0) begin errorCount++; $display("[TB] FAIL race_second_expiry got %b want 0", bus.link_up); end
    checkCount++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_held_ready();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.data_rec   = 8'h03;
    bus.data_error = 1'b0;
    bus.data_ready = 1'b1;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (bus.new_frame === 1'b1) pulses++;
    end
    if (pulses !== 1) begin errorCount++; $display("[TB] FAIL held_pulses got %0d want 1", pulses); end
    checkCount++;
    if (bus.link_up !== 1'b0) begin errorCount++; $display("[TB] FAIL held_link got %b want 0", bus.link_up); end
    checkCount++;
    if (bus.sensor !== 4'b0111) begin errorCount++; $display("[TB] FAIL held_sensor got %b want 0111", bus.sensor); end
    checkCount++;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.data_rec   = 8'h02;
    bus.data_error = 1'b0;
    bus.data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (bus.sensor !== 4'b0010) begin errorCount++; $display("[TB] FAIL ar_pre_sensor got %b want 0010", bus.sensor); end
    checkCount++;
    #2;
    rst = 1'b1;
    #1;
    if (bus.sensor !== 4'b0111) begin errorCount++; $display("[TB] FAIL ar_sensor got %b want 0111", bus.sensor); end
    checkCount++;
    if (bus.link_up !== 1'b0) begin errorCount++; $display("[TB] FAIL ar_link_up got %b want 0", bus.link_up); end
    checkCount++;
    if (bus.new_frame !== 1'b0) begin errorCount++; $display("[TB] FAIL ar_new_frame got %b want 0", bus.new_frame); end
    checkCount++;
    if (bus.err_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL ar_err_cnt got %0d want 0", bus.err_cnt); end
    checkCount++;
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (bus.new_frame !== 1'b0) begin errorCount++; $display("[TB] FAIL ar_edge_early got %b want 0", bus.new_frame); end
    checkCount++;
    @(posedge clk);
    #1;
    if (bus.new_frame !== 1'b1) begin errorCount++; $display("[TB] FAIL ar_edge_frame got %b want 1", bus.new_frame); end
    checkCount++;
    if (bus.sensor !== 4'b0010) begin errorCount++; $display("[TB] FAIL ar_edge_sensor got %b want 0010", bus.sensor); end
    checkCount++;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Run every scenario in order, then report
  initial begin
    bus.data_rec   = 8'h00;
    bus.data_ready = 1'b0;
    bus.data_error = 1'b0;
    test_reset();
    test_first_frame();
    test_filter();
    test_errors();
    test_timeout();
    test_expiry_race();
    test_held_ready();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
